// File: rtl/ctrl_cfg_sequencer.sv
// Layer descriptor sequencer: double-buffered descriptor store feeding a control unit run handshake.
// Optional watchdog enabled by defining CFG_SEQ_TIMEOUT_EN.
module ctrl_cfg_sequencer #(
  parameter int Pa      = 8,
  parameter int Pw      = 4,
  parameter int MNO     = 288,
  parameter int MNV     = 224*224,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(MNO)-1:0]    cfg_done_cnt,
  input  logic [$clog2(Pa*Pw)-1:0]  cfg_quant,
  input  logic [2:0]                cfg_out,
  input  logic [2:0]                cfg_relu,
  input  logic [2:0]                cfg_fil_group,
  input  logic [$clog2(MNV)-1:0]    cfg_in_vol,
  input  logic [$clog2(MNV)-1:0]    cfg_wb_last,
  input  logic                      abort,
  input  logic                      wb,
  output logic [$clog2(MNO)-1:0]    max_val_cnt_done,
  output logic [$clog2(Pa*Pw)-1:0]  max_val_cnt_quant,
  output logic [2:0]                max_val_cnt_out,
  output logic [2:0]                max_val_cnt_relu,
  output logic [2:0]                max_val_fil_group,
  output logic [$clog2(MNV)-1:0]    max_val_in_vol,
  output logic                      core_stall_n,
  output logic                      busy,
  output logic                      layer_done,
  output logic                      timeout_err
);

  localparam int DW = $clog2(MNO);
  localparam int QW = $clog2(Pa*Pw);
  localparam int VW = $clog2(MNV);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ctrl_cfg_sequencer: TIMEOUT must be at least 2");
  end

  typedef struct packed {
    logic [DW-1:0] done_cnt;
    logic [QW-1:0] quant;
    logic [2:0]    out;
    logic [2:0]    relu;
    logic [2:0]    fil_group;
    logic [VW-1:0] in_vol;
    logic [VW-1:0] wb_last;
  } desc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_DONE} state_e;

  state_e        state_q, state_d;
  desc_t         a_q, a_d;
  desc_t         s_q, s_d;
  logic          s_full_q, s_full_d;
  logic [VW-1:0] wb_cnt_q, wb_cnt_d;
  logic          layer_done_q, layer_done_d;
  desc_t         cfg_in;
  logic          accept;

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT);
  logic [WDW-1:0] wd_q, wd_d;
  logic           timeout_err_q, timeout_err_d;
`endif

  assign cfg_in = '{done_cnt: cfg_done_cnt, quant: cfg_quant, out: cfg_out,
                    relu: cfg_relu, fil_group: cfg_fil_group,
                    in_vol: cfg_in_vol, wb_last: cfg_wb_last};

  assign cfg_ready = !s_full_q && !abort && rst_n;
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    a_d          = a_q;
    s_d          = s_q;
    s_full_d     = s_full_q;
    wb_cnt_d     = wb_cnt_q;
    layer_done_d = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = 1'b0;
`endif

    // Outside IDLE an accepted descriptor waits in the shadow slot.
    if (accept && state_q != ST_IDLE) begin
      s_d      = cfg_in;
      s_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = cfg_in;
          state_d = ST_SETUP;
`ifdef CFG_SEQ_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      ST_SETUP: begin
        wb_cnt_d = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (wb) begin
          if (wb_cnt_q == a_q.wb_last) begin
            state_d      = ST_DONE;
            layer_done_d = 1'b1;
          end else begin
            wb_cnt_d = wb_cnt_q + VW'(1);
          end
`ifdef CFG_SEQ_TIMEOUT_EN
          wd_d = '0;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_d       = ST_DONE;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
`endif
        end
      end
      ST_DONE: begin
        // A descriptor arriving this very cycle counts as a full shadow slot.
        if (s_full_q || accept) begin
          a_d      = s_full_q ? s_q : cfg_in;
          s_full_d = 1'b0;
          state_d  = ST_SETUP;
`ifdef CFG_SEQ_TIMEOUT_EN
          wd_d     = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a coincident terminal writeback.
    if (abort) begin
      state_d      = ST_IDLE;
      s_full_d     = 1'b0;
      layer_done_d = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
      timeout_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      s_q          <= '0;
      s_full_q     <= 1'b0;
      wb_cnt_q     <= '0;
      layer_done_q <= 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      s_q          <= s_d;
      s_full_q     <= s_full_d;
      wb_cnt_q     <= wb_cnt_d;
      layer_done_q <= layer_done_d;
`ifdef CFG_SEQ_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // A only changes when entering SETUP, so the counter programming settles before RUN.
  assign max_val_cnt_done  = a_q.done_cnt;
  assign max_val_cnt_quant = a_q.quant;
  assign max_val_cnt_out   = a_q.out;
  assign max_val_cnt_relu  = a_q.relu;
  assign max_val_fil_group = a_q.fil_group;
  assign max_val_in_vol    = a_q.in_vol;

  assign core_stall_n = (state_q == ST_RUN);
  assign busy         = (state_q != ST_IDLE);
  assign layer_done   = layer_done_q;

`ifdef CFG_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_cfg_sequencer.sv
// Self-checking bench for ctrl_cfg_sequencer: cycle vector table through a scoreboard queue,
// plus a hand-written watchdog sequence whose expectation follows CFG_SEQ_TIMEOUT_EN.
module tb_ctrl_cfg_sequencer;

  localparam int Pa = 8, Pw = 4, MNO = 288, MNV = 224*224, TO = 16;
  localparam int DW = $clog2(MNO), QW = $clog2(Pa*Pw), VW = $clog2(MNV);

  logic          clk = 1'b0;
  logic          rst_n, cfg_valid, cfg_ready, abort, wb;
  logic [DW-1:0] cfg_done_cnt, max_val_cnt_done;
  logic [QW-1:0] cfg_quant, max_val_cnt_quant;
  logic [2:0]    cfg_out, cfg_relu, cfg_fil_group;
  logic [2:0]    max_val_cnt_out, max_val_cnt_relu, max_val_fil_group;
  logic [VW-1:0] cfg_in_vol, cfg_wb_last, max_val_in_vol;
  logic          core_stall_n, busy, layer_done, timeout_err;

  ctrl_cfg_sequencer #(.Pa(Pa), .Pw(Pw), .MNO(MNO), .MNV(MNV), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_done_cnt(cfg_done_cnt), .cfg_quant(cfg_quant), .cfg_out(cfg_out),
    .cfg_relu(cfg_relu), .cfg_fil_group(cfg_fil_group), .cfg_in_vol(cfg_in_vol),
    .cfg_wb_last(cfg_wb_last), .abort(abort), .wb(wb),
    .max_val_cnt_done(max_val_cnt_done), .max_val_cnt_quant(max_val_cnt_quant),
    .max_val_cnt_out(max_val_cnt_out), .max_val_cnt_relu(max_val_cnt_relu),
    .max_val_fil_group(max_val_fil_group), .max_val_in_vol(max_val_in_vol),
    .core_stall_n(core_stall_n), .busy(busy), .layer_done(layer_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_n, valid, wb, abort;
    int wbl, vol;
    bit sn, busy, done, rdy;
    int mvol;
  } vec_t;

  typedef struct {
    bit sn, busy, done, terr, rdy;
    int mvol;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t v(input bit r, va, w, ab, input int wbl, vol,
                             input bit sn, b, d, rdy, input int mv);
    vec_t t;
    t.rst_n = r; t.valid = va; t.wb = w; t.abort = ab; t.wbl = wbl; t.vol = vol;
    t.sn = sn; t.busy = b; t.done = d; t.rdy = rdy; t.mvol = mv;
    return t;
  endfunction

  // Secondary descriptor fields are derived from in_vol so a field swap shows up.
  function automatic logic [22:0] fields_of(input int vol);
    logic [15:0] t;
    t = vol[15:0];
    return {t[8:0] ^ 9'h1a5, t[4:0] + 5'd3, t[2:0], ~t[2:0], t[5:3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, va, w, ab, input int wbl, vol);
    rst_n       = r;
    cfg_valid   = va;
    wb          = w;
    abort       = ab;
    cfg_wb_last = wbl[VW-1:0];
    cfg_in_vol  = vol[VW-1:0];
    {cfg_done_cnt, cfg_quant, cfg_out, cfg_relu, cfg_fil_group} = fields_of(vol);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [22:0] exp_f;
    bit seen;

    drive(0, 0, 0, 0, 0, 0);

    //            rst va wb ab wbl vol   sn b  d  rdy mvol
    // reset
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0));    // r0
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0));    // r1
    // single layer, wb_last=3
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0));    // r2 idle
    vecs.push_back(v(1, 1, 0, 0, 3, 100,  0, 1, 0, 1, 100));  // r3 accept -> SETUP
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 100));  // r4 RUN
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 100));  // r5 wb#1
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 100));  // r6 wb#2
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 100));  // r7
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 100));  // r8 wb#3
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 1, 100));  // r9 wb#4 -> DONE
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 100));  // r10 IDLE
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 100));  // r11
    // back-to-back through the shadow slot
    vecs.push_back(v(1, 1, 0, 0, 1, 50,   0, 1, 0, 1, 50));   // r12
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 50));   // r13 RUN
    vecs.push_back(v(1, 1, 0, 0, 0, 60,   1, 1, 0, 0, 50));   // r14 fill S
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 0, 50));   // r15
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 0, 50));   // r16 DONE
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 1, 0, 1, 60));   // r17 SETUP, S->A
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 60));   // r18 RUN
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 1, 60));   // r19 DONE
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 60));   // r20 IDLE
    // accept coinciding with DONE, S empty
    vecs.push_back(v(1, 1, 0, 0, 0, 70,   0, 1, 0, 1, 70));   // r21
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 70));   // r22
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 1, 70));   // r23 DONE
    vecs.push_back(v(1, 1, 0, 0, 0, 80,   0, 1, 0, 1, 80));   // r24 -> SETUP with new desc
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 80));   // r25
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 1, 80));   // r26
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 80));   // r27
    // abort on terminal wb with S full
    vecs.push_back(v(1, 1, 0, 0, 1, 90,   0, 1, 0, 1, 90));   // r28
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 90));   // r29
    vecs.push_back(v(1, 1, 0, 0, 2, 91,   1, 1, 0, 0, 90));   // r30 fill S
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 0, 90));   // r31
    vecs.push_back(v(1, 0, 1, 1, 0, 0,    0, 0, 0, 0, 90));   // r32 terminal wb + abort
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 90));   // r33
    // stray wb in IDLE and SETUP, wb_last=0
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 0, 0, 1, 90));   // r34
    vecs.push_back(v(1, 1, 1, 0, 0, 5,    0, 1, 0, 1, 5));    // r35
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 5));    // r36 wb in SETUP
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 5));    // r37
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 1, 5));    // r38 first wb in RUN
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 5));    // r39
    // reset mid-RUN after 2 of 5 wb
    vecs.push_back(v(1, 1, 0, 0, 4, 33,   0, 1, 0, 1, 33));   // r40
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 33));   // r41
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 33));   // r42
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 33));   // r43
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0));    // r44 reset
    vecs.push_back(v(1, 1, 0, 0, 1, 44,   0, 1, 0, 1, 44));   // r45
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    1, 1, 0, 1, 44));   // r46
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    1, 1, 0, 1, 44));   // r47
    vecs.push_back(v(1, 0, 1, 0, 0, 0,    0, 1, 1, 1, 44));   // r48
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 44));   // r49
    // abort during SETUP
    vecs.push_back(v(1, 1, 0, 0, 0, 12,   0, 1, 0, 1, 12));   // r50
    vecs.push_back(v(1, 0, 0, 1, 0, 0,    0, 0, 0, 0, 12));   // r51
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 12));   // r52

    foreach (vecs[i]) begin
      exp_t x;
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].valid, vecs[i].wb, vecs[i].abort, vecs[i].wbl, vecs[i].vol);
      x.sn = vecs[i].sn; x.busy = vecs[i].busy; x.done = vecs[i].done;
      x.terr = 1'b0; x.rdy = vecs[i].rdy; x.mvol = vecs[i].mvol;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      exp_f = (e.mvol == 0) ? '0 : fields_of(e.mvol);
      check($sformatf("r%0d.core_stall_n", i), 32'(core_stall_n), 32'(e.sn));
      check($sformatf("r%0d.busy", i), 32'(busy), 32'(e.busy));
      check($sformatf("r%0d.layer_done", i), 32'(layer_done), 32'(e.done));
      check($sformatf("r%0d.timeout_err", i), 32'(timeout_err), 32'(e.terr));
      check($sformatf("r%0d.cfg_ready", i), 32'(cfg_ready), 32'(e.rdy));
      check($sformatf("r%0d.max_val_in_vol", i), 32'(max_val_in_vol), e.mvol);
      check($sformatf("r%0d.max_val_fields", i),
            32'({max_val_cnt_done, max_val_cnt_quant, max_val_cnt_out,
                 max_val_cnt_relu, max_val_fil_group}), 32'(exp_f));
    end

    // Watchdog: a layer that never sees a writeback.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 7);
    @(posedge clk); #1;
    check("to.setup_busy", 32'(busy), 32'd1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("to.run_entry", 32'(core_stall_n), 32'd1);
`ifdef CFG_SEQ_TIMEOUT_EN
    seen = 1'b0;
    for (int k = 1; k < TO; k++) begin
      @(posedge clk); #1;
      if (timeout_err || layer_done || !core_stall_n) seen = 1'b1;
    end
    check("to.no_early_exit", 32'(seen), 32'd0);
    @(posedge clk); #1;
    check("to.timeout_pulse", 32'(timeout_err), 32'd1);
    check("to.no_layer_done", 32'(layer_done), 32'd0);
    check("to.stall_dropped", 32'(core_stall_n), 32'd0);
    check("to.in_done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("to.pulse_one_cycle", 32'(timeout_err), 32'd0);
    check("to.back_to_idle", 32'(busy), 32'd0);
    check("to.no_late_done", 32'(layer_done), 32'd0);
`else
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (timeout_err || layer_done || !core_stall_n) seen = 1'b1;
    end
    check("to.waits_in_run", 32'(seen), 32'd0);
    check("to.still_running", 32'(core_stall_n), 32'd1);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    check("to.abort_stall", 32'(core_stall_n), 32'd0);
    check("to.abort_idle", 32'(busy), 32'd0);
    check("to.abort_no_done", 32'(layer_done), 32'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_cfg_sequencer.md
CTRL_CFG_SEQUENCER -- requirements
Module: ctrl_cfg_sequencer

Interface
REQ-001 Parameters SHALL be: Pa, default 8, activation parallelism; Pw, default 4, weight parallelism; MNO, default 288, max ops per output; MNV, default 224*224, max input volume; TIMEOUT, default 1024, watchdog limit in cycles.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  layer descriptor offered.
- cfg_ready  out  1  descriptor accepted when cfg_valid&cfg_ready.
- cfg_done_cnt  in  $clog2(MNO)  descriptor field.
- cfg_quant  in  $clog2(Pa*Pw)  descriptor field.
- cfg_out, cfg_relu, cfg_fil_group  in  3 each  descriptor fields.
- cfg_in_vol  in  $clog2(MNV)  descriptor field.
- cfg_wb_last  in  $clog2(MNV)  expected wb pulses for the layer, minus 1.
- abort  in  1  cancel current and pending layer.
- wb  in  1  writeback pulse from the control unit.
- max_val_cnt_done, max_val_cnt_quant, max_val_cnt_out, max_val_cnt_relu, max_val_fil_group, max_val_in_vol  out  same widths as the cfg fields  programming of the control unit counters.
- core_stall_n  out  1  run handshake to the control unit.
- busy  out  1  high in any state other than IDLE.
- layer_done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle watchdog pulse.

Function
REQ-003 The block SHALL hold a two-entry descriptor store: active register A and shadow register S.
REQ-004 cfg_ready SHALL be 1 when S is empty, abort=0 and rst_n=1; otherwise it SHALL be 0.
- In IDLE an accepted descriptor SHALL load A directly.
- In every other state it SHALL load S.
REQ-005 The FSM SHALL have the states IDLE, SETUP, RUN and DONE.
- IDLE->SETUP on accept.
- SETUP->RUN after exactly 1 cycle.
- RUN->DONE on the cycle where wb=1 and wb_cnt==A.wb_last.
- DONE->SETUP if S is full; S SHALL move to A in the same cycle.
- DONE->IDLE if S is empty.
REQ-006 The max_val_* outputs SHALL be driven from register A.
- They SHALL change only on the SETUP-entry edge.
- They SHALL therefore be stable for at least 1 cycle before core_stall_n rises.
REQ-007 core_stall_n SHALL be 1 only in RUN. It SHALL rise on the cycle after SETUP and fall on the cycle after the terminal wb.
REQ-008 wb_cnt ($clog2(MNV) bits) SHALL behave as follows:
- Cleared in SETUP.
- Incremented on each wb in RUN.
- Never wraps; the terminal compare fires first.
REQ-009 wb asserted outside RUN SHALL be ignored. It SHALL NOT affect the counter or the state.
REQ-010 layer_done SHALL pulse for exactly the 1 cycle spent in DONE. With S full, back-to-back layers SHALL have a 2-cycle core_stall_n low gap (DONE plus SETUP).
REQ-011 cfg_wb_last=0 SHALL complete on the first wb in RUN.
REQ-012 abort=1 in any state SHALL, on the next edge:
- enter IDLE;
- empty S;
- drop core_stall_n;
- suppress layer_done.
The max_val_* outputs SHALL retain their values.
REQ-013 When abort coincides with the terminal wb, abort SHALL win: there SHALL be no layer_done pulse.
REQ-014 When accept coincides with DONE and S is empty, the new descriptor SHALL go to S and the FSM SHALL go to SETUP with it in the same cycle. Equivalently, an S fill and the DONE decision in the same cycle SHALL behave as if S were full.

Reset
REQ-015 With rst_n=0 at a rising edge, the block SHALL apply these values on that edge:
- state IDLE; A and S cleared; S empty; wb_cnt=0.
- all max_val_*=0.
- core_stall_n=0, busy=0, layer_done=0, timeout_err=0.
- cfg_ready SHALL be 0 while rst_n=0.
REQ-016 Reset during RUN SHALL drop core_stall_n on that edge and SHALL discard all descriptors.

Configuration
REQ-017 With macro CFG_SEQ_TIMEOUT_EN defined, the watchdog SHALL be present:
- A watchdog counter SHALL clear on SETUP entry and on every wb in RUN, and SHALL increment on every other RUN cycle.
- On reaching TIMEOUT-1 the block SHALL pulse timeout_err for 1 cycle and SHALL enter DONE without a layer_done pulse.
REQ-018 With CFG_SEQ_TIMEOUT_EN undefined, no watchdog logic SHALL be present, timeout_err SHALL be tied to 0, and RUN SHALL wait indefinitely.

Verification
REQ-019 Single layer: accept cfg_wb_last=3 and cfg_in_vol=100 in IDLE, then 4 wb pulses -> max_val_in_vol=100 before core_stall_n rises; core_stall_n high from accept+2 to terminal wb+1; one layer_done.
REQ-020 Back-to-back layers: accept descriptor 2 during RUN of descriptor 1 -> cfg_ready=0 afterwards; max_val_* update at SETUP; 2-cycle core_stall_n low gap; two layer_done pulses.
REQ-021 Abort: abort on the terminal wb cycle with S full -> IDLE, core_stall_n=0, no layer_done, S empty, cfg_ready=1 on the next cycle.
REQ-022 Stray wb: wb pulses in IDLE and SETUP, then cfg_wb_last=0 -> completion on the first wb inside RUN only.
REQ-023 Reset mid-RUN: rst_n=0 for 1 cycle after 2 of 5 wb -> all outputs at reset values; the next layer counts from 0.
REQ-024 Timeout (macro defined, TIMEOUT=16): no wb in RUN -> timeout_err pulse 16 cycles after RUN entry; no layer_done.
REQ-025 Timeout (macro undefined): same stimulus as REQ-024 -> stays in RUN; timeout_err stays 0.
